// File: rtl/register_file_param.sv
// Parametrised register file with write-to-read bypass, pending-write scoreboard
// and a sequenced clear engine that zeroes one entry per cycle.
module register_file_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      cclk,
    input  logic                      rstb,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         write_reg,
    input  logic [WIDTH-1:0]          write_data,
    input  logic [NREAD*ADDR_W-1:0]   read_reg,
    output logic [NREAD*WIDTH-1:0]    read_data,
    output logic [NREAD-1:0]          read_busy,
    input  logic                      reserve,
    input  logic [ADDR_W-1:0]         reserve_reg,
    input  logic                      clear_start,
    output logic                      clear_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clear_idx;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]    busy;

    logic write_ok;
    logic reserve_ok;

    // Entry 0 swallows writes and reservations when it is hardwired to zero.
    assign write_ok   = write && !((ZERO_REG != 0) && (write_reg == '0));
    assign reserve_ok = reserve && !((ZERO_REG != 0) && (reserve_reg == '0));

    always_ff @(posedge cclk) begin
        if (rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_start) state_d = CLEAR;
            CLEAR:   if (&clear_idx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state_q == CLEAR);
    end

    // In CLEAR every port-side request is dropped; the engine owns the array.
    always_ff @(posedge cclk) begin
        if (rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy      <= '0;
            clear_idx <= '0;
        end else if (state_q == IDLE) begin
            if (write_ok) begin
                mem[write_reg] <= write_data;
            end
            if (clear_start) begin
                busy      <= '0;
                clear_idx <= '0;
            end else begin
                if (write) begin
                    busy[write_reg] <= 1'b0;
                end
                if (reserve_ok) begin
                    busy[reserve_reg] <= 1'b1;
                end
            end
        end else begin
            mem[clear_idx] <= '0;
            clear_idx      <= clear_idx + 1'b1;
        end
    end

    // Busy is deliberately not bypassed: a retiring write frees the entry next cycle.
    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            logic [ADDR_W-1:0] addr;
            addr = read_reg[p*ADDR_W +: ADDR_W];
            read_busy[p] = busy[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                read_data[p*WIDTH +: WIDTH] = '0;
            end else if ((BYPASS != 0) && (state_q == IDLE) && write && (write_reg == addr)) begin
                read_data[p*WIDTH +: WIDTH] = write_data;
            end else begin
                read_data[p*WIDTH +: WIDTH] = mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: directed scenarios plus a random
// phase, compared against a behavioural model of the register file.
module tb_register_file_param;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                    cclk = 1'b0;
    logic                    rstb;
    logic                    write;
    logic [ADDR_W-1:0]       write_reg;
    logic [WIDTH-1:0]        write_data;
    logic [NREAD*ADDR_W-1:0] read_reg;
    logic [NREAD*WIDTH-1:0]  read_data;
    logic [NREAD-1:0]        read_busy;
    logic                    reserve;
    logic [ADDR_W-1:0]       reserve_reg;
    logic                    clear_start;
    logic                    clear_busy;
    logic [NREAD*WIDTH-1:0]  read_data_nb;
    logic [NREAD-1:0]        read_busy_nb;
    logic                    clear_busy_nb;

    always #5 cclk = ~cclk;

    register_file_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(1)) dut (
        .cclk(cclk), .rstb(rstb), .write(write), .write_reg(write_reg), .write_data(write_data),
        .read_reg(read_reg), .read_data(read_data), .read_busy(read_busy),
        .reserve(reserve), .reserve_reg(reserve_reg),
        .clear_start(clear_start), .clear_busy(clear_busy)
    );

    register_file_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .cclk(cclk), .rstb(rstb), .write(write), .write_reg(write_reg), .write_data(write_data),
        .read_reg(read_reg), .read_data(read_data_nb), .read_busy(read_busy_nb),
        .reserve(reserve), .reserve_reg(reserve_reg),
        .clear_start(clear_start), .clear_busy(clear_busy_nb)
    );

    // Model: plain array contents, a busy flag per entry and a count of clear cycles left.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               ref_busy [DEPTH];
    int               clear_left;
    int               total;
    int               bad;
    bit               checks_on;

    task automatic compare(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        int               a;
        logic [WIDTH-1:0] exp_plain;
        logic [WIDTH-1:0] exp_byp;
        for (int p = 0; p < NREAD; p++) begin
            a         = int'(read_reg[p*ADDR_W +: ADDR_W]);
            exp_plain = (a == 0) ? '0 : ref_mem[a];
            exp_byp   = exp_plain;
            if (clear_left == 0 && write && a != 0 && int'(write_reg) == a) exp_byp = write_data;
            compare($sformatf("rd%0d_r%0d", p, a), read_data[p*WIDTH +: WIDTH], exp_byp);
            compare($sformatf("rdnb%0d_r%0d", p, a), read_data_nb[p*WIDTH +: WIDTH], exp_plain);
            compare($sformatf("busy%0d_r%0d", p, a), WIDTH'(read_busy[p]), WIDTH'(ref_busy[a]));
        end
        compare("clear_busy", WIDTH'(clear_busy), WIDTH'(clear_left > 0));
        compare("clear_busy_nb", WIDTH'(clear_busy_nb), WIDTH'(clear_left > 0));
    endtask

    task automatic model_edge();
        if (rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i]  = '0;
                ref_busy[i] = 1'b0;
            end
            clear_left = 0;
        end else if (clear_left > 0) begin
            ref_mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            if (write && write_reg != 0) ref_mem[write_reg] = write_data;
            if (write) ref_busy[write_reg] = 1'b0;
            if (reserve && reserve_reg != 0) ref_busy[reserve_reg] = 1'b1;
            if (clear_start) begin
                for (int i = 0; i < DEPTH; i++) ref_busy[i] = 1'b0;
                clear_left = DEPTH;
            end
        end
    endtask

    // One clock cycle: drive, let reads settle, check, then advance model with the edge.
    task automatic apply_stimulus(input logic rst, input logic wr, input logic [ADDR_W-1:0] wreg,
                                  input logic [WIDTH-1:0] wdata, input logic rsv,
                                  input logic [ADDR_W-1:0] rreg, input logic clr,
                                  input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
        rstb        = rst;
        write       = wr;
        write_reg   = wreg;
        write_data  = wdata;
        reserve     = rsv;
        reserve_reg = rreg;
        clear_start = clr;
        read_reg    = {ra1, ra0};
        #2;
        if (checks_on) check_output();
        @(posedge cclk);
        model_edge();
        #1;
    endtask

    task automatic read_pair(input int r0, input int r1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ADDR_W'(r0), ADDR_W'(r1));
    endtask

    task automatic sweep_all();
        for (int r = 0; r < DEPTH; r += 2) read_pair(r, r + 1);
    endtask

    task automatic fill_nonzero();
        for (int r = 1; r < DEPTH; r++) begin
            apply_stimulus(1'b0, 1'b1, ADDR_W'(r), WIDTH'($urandom) | 32'h1, 1'b1,
                           ADDR_W'((r * 7) % DEPTH), 1'b0, ADDR_W'(r), ADDR_W'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n_clear;
        total = 0;
        bad = 0;
        checks_on = 0;
        clear_left = 0;
        rstb = 1'b0; write = 1'b0; write_reg = '0; write_data = '0;
        reserve = 1'b0; reserve_reg = '0; clear_start = 1'b0; read_reg = '0;
        @(posedge cclk);
        #1;

        $display("[TB] reset");
        apply_stimulus(1'b1, 1'b1, 5'd3, 32'h1111_2222, 1'b1, 5'd4, 1'b0, 5'd5, 5'd31);
        checks_on = 1;
        read_pair(5, 31);

        $display("[TB] write and read");
        apply_stimulus(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, 5'd1, 5'd2);
        read_pair(7, 0);
        apply_stimulus(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, 1'b0, 5'd0, 5'd0);
        read_pair(0, 7);

        $display("[TB] bypass");
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, '0, 1'b0, 5'd7, 5'd3);
        read_pair(3, 3);
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'h5A5A_5A5A, 1'b0, '0, 1'b0, 5'd3, 5'd3);

        $display("[TB] scoreboard");
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        read_pair(9, 3);
        apply_stimulus(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, '0, 1'b0, 5'd9, 5'd9);
        read_pair(9, 9);
        apply_stimulus(1'b0, 1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        read_pair(9, 9);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd9);
        read_pair(0, 9);

        $display("[TB] full clear");
        fill_nonzero();
        apply_stimulus(1'b0, 1'b1, 5'd12, 32'h1212_1212, 1'b1, 5'd13, 1'b1, 5'd12, 5'd13);
        n_clear = 0;
        for (int c = 0; c < 100; c++) begin
            if (!clear_busy) break;
            n_clear++;
            if (c == 5)
                apply_stimulus(1'b0, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4, 1'b1, 5'd4, 5'd31);
            else
                apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ADDR_W'($urandom), ADDR_W'(c));
        end
        compare("clear_len", WIDTH'(n_clear), WIDTH'(DEPTH));
        sweep_all();

        $display("[TB] reset during clear");
        fill_nonzero();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd1, 5'd30);
        for (int c = 1; c < 10; c++) read_pair(c, 30);
        apply_stimulus(1'b1, 1'b1, 5'd20, 32'h2020_2020, 1'b0, '0, 1'b0, 5'd20, 5'd30);
        sweep_all();
        apply_stimulus(1'b0, 1'b1, 5'd20, 32'h0F0F_F0F0, 1'b0, '0, 1'b0, 5'd21, 5'd20);
        read_pair(20, 21);

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] r0;
            logic [ADDR_W-1:0] r1;
            r0 = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            r1 = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                           ADDR_W'($urandom_range(0, 7)), WIDTH'($urandom),
                           $urandom_range(0, 2) == 0, ADDR_W'($urandom_range(0, 7)),
                           $urandom_range(0, 79) == 0, r0, r1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the MIPS-stub 32x32 register file. Width, depth and read-port count are set by parameters, and register 0 can optionally be hardwired to zero. The block adds write-to-read bypass, a per-register pending-write scoreboard, and a sequenced clear engine that zeroes the array one entry per cycle. It sits between decode (read ports, reserve) and writeback (write port) of the CPU datapath.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NREAD, 2, number of independent combinational read ports
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
cclk  input  1  clock, all state updates on rising edge
rstb  input  1  reset, synchronous, active-high
write  input  1  write enable for write port
write_reg  input  ADDR_W  write address
write_data  input  WIDTH  write data
read_reg  input  NREAD*ADDR_W  read addresses; port p is bits [p*ADDR_W +: ADDR_W]
read_data  output  NREAD*WIDTH  read data; port p is bits [p*WIDTH +: WIDTH]
read_busy  output  NREAD  scoreboard bit of the entry addressed by each read port
reserve  input  1  mark reserve_reg as pending-write
reserve_reg  input  ADDR_W  entry to reserve
clear_start  input  1  request full-array clear
clear_busy  output  1  high while the clear engine is running

Behaviour:
- Reset (rstb=1 at edge): all entries = 0; all scoreboard bits = 0; FSM = IDLE; clear index = 0. Since read_data and read_busy are combinational, both are 0 in the cycle after reset, and clear_busy = 0. Reset overrides every other input, including a clear in progress.
- Read (combinational, 0-cycle latency):
  - read_data[p] = array[read_reg[p]].
  - If ZERO_REG=1 and read_reg[p]=0, read_data[p] = 0.
  - Bypass applies when BYPASS=1, FSM=IDLE, write=1, write_reg==read_reg[p], and the address is not the zero register. Under bypass, read_data[p] = write_data.
- Write: in IDLE with write=1, array[write_reg] <= write_data at the rising edge. The write is ignored when ZERO_REG=1 and write_reg=0.
- Scoreboard: one bit per entry.
  - reserve=1 in IDLE sets busy[reserve_reg].
  - A write in IDLE clears busy[write_reg].
  - If reserve and write target the same entry in the same cycle, the reserve wins: the bit ends set and the data is still written.
  - With ZERO_REG=1, entry 0 is never set.
  - read_busy[p] = busy[read_reg[p]]. It is not bypassed: a write in the current cycle does not clear read_busy until the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_start=1. At that edge: all scoreboard bits cleared, clear index = 0. Write and reserve in that same cycle are still performed, but reserve is overridden by the scoreboard clear.
  - In CLEAR: each edge sets array[index] <= 0 and index <= index+1. When index = DEPTH-1, the entry is zeroed and the next state is IDLE. Total CLEAR duration is exactly DEPTH cycles.
  - clear_busy = 1 iff the state is CLEAR.
  - In CLEAR, write, reserve and clear_start are ignored (dropped, not queued), and bypass is disabled. Reads return the current array contents, so already-cleared entries read 0 and the rest hold old values.
  - The index wraps naturally at ADDR_W bits and is not used past DEPTH-1.
- Width rules: no arithmetic on data; addresses are unsigned. An out-of-range address cannot occur because DEPTH = 2**ADDR_W.

Test Plan:
- Reset then read: assert rstb for 1 cycle, then read ports 0/1 at regs 5/31 -> read_data 0, read_busy 0, clear_busy 0.
- Write/read: write reg 7 = 0xDEADBEEF; next cycle read_reg[0]=7 -> 0xDEADBEEF. Write reg 0 = 0x1234 with ZERO_REG=1 -> reg 0 reads 0.
- Bypass: same cycle write reg 3 = 0xA5A5A5A5 and read_reg[1]=3 -> read_data[1]=0xA5A5A5A5 in that cycle. With BYPASS=0 build -> old value until the next cycle.
- Scoreboard:
  - Reserve reg 9 -> read_busy 1 next cycle; write reg 9 -> busy 0 the cycle after.
  - Simultaneous reserve and write on reg 9 -> busy 1, data written.
  - Reserve reg 0 -> busy stays 0.
- Clear: fill regs 1..31 with nonzero values, pulse clear_start -> clear_busy high for exactly 32 cycles, all regs 0 and all busy 0 afterwards. A write to reg 4 issued mid-clear is dropped (reg 4 reads 0 after the clear).
- Reset mid-clear: clear_start, then rstb on clear cycle 10 -> clear_busy 0 next cycle and all entries 0. A new write then succeeds normally.
